// File: rtl/inst_mem_loadable.sv
// Byte-addressed little-endian instruction memory with a registered fetch port and a run-time byte loader.
// Define IMEM_PARITY_EN to store and check one parity bit per byte.
module inst_mem_loadable #(
    parameter int    ADDR_W      = 8,
    parameter int    FETCH_BYTES = 4,
    parameter bit    BOOT_LOAD   = 1'b0,
    parameter string INIT_FILE   = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [8*FETCH_BYTES-1:0] fetch_data,
    output logic [1:0]               fetch_err,
    input  logic                     prog_start,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [7:0]               prog_wdata,
    input  logic                     prog_done,
    output logic [ADDR_W:0]          prog_cnt,
    output logic                     prog_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DW    = 8 * FETCH_BYTES;
    localparam int OFF_W = $clog2(FETCH_BYTES);
    localparam logic [DW-1:0] NOP_PAT = (FETCH_BYTES == 2) ? DW'(16'h0001) : DW'(32'h0000_0013);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic               fetch_valid_q, fetch_valid_d;
    logic [DW-1:0]      fetch_data_q, fetch_data_d;
    logic [1:0]         fetch_err_q, fetch_err_d;
    logic [ADDR_W:0]    prog_cnt_q, prog_cnt_d;
    logic               prog_err_q, prog_err_d;

    logic               run_s;
    logic               load_s;
    logic               fetch_acc_s;
    logic               mis_s;
    logic               oor_s;
    logic               par_bad_s;
    logic               wr_ok_s;
    logic               mem_we_s;
    logic [ADDR_W:0]    end_s;
    logic [DW-1:0]      raw_s;

`ifdef IMEM_PARITY_EN
    logic               par_q [DEPTH];
    logic               wr_par_s;

    function automatic logic par8(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT_LOAD ? ST_LOAD : ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: prog_done has priority over prog_start while running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (prog_start && !prog_done) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (prog_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Controller outputs
    always_comb begin
        run_s       = (state_q == ST_RUN);
        load_s      = (state_q == ST_LOAD);
        fetch_acc_s = fetch_req && run_s;
        fetch_ready = run_s;
    end

    // Fetch path: fault detection and byte gathering
    always_comb begin
        raw_s     = '0;
        par_bad_s = 1'b0;
        mis_s     = (fetch_addr[OFF_W-1:0] != '0);
        end_s     = {1'b0, fetch_addr} + (ADDR_W+1)'(FETCH_BYTES);
        oor_s     = (end_s > (ADDR_W+1)'(DEPTH));
        for (int i = 0; i < FETCH_BYTES; i++) begin
            raw_s[8*i +: 8] = mem_q[fetch_addr + ADDR_W'(i)];
`ifdef IMEM_PARITY_EN
            par_bad_s = par_bad_s | (par_q[fetch_addr + ADDR_W'(i)] != par8(mem_q[fetch_addr + ADDR_W'(i)]));
`endif
        end
        fetch_valid_d = fetch_acc_s;
        if (fetch_acc_s) begin
            fetch_err_d  = {oor_s | par_bad_s, mis_s};
            fetch_data_d = (oor_s || par_bad_s || mis_s) ? NOP_PAT : raw_s;
        end else begin
            fetch_err_d  = fetch_err_q;
            fetch_data_d = fetch_data_q;
        end
    end

    // Loader path: write qualification, byte counter and drop flag
    always_comb begin
`ifdef IMEM_PARITY_EN
        wr_par_s = par8(prog_wdata);
        wr_ok_s  = (wr_par_s == par8(prog_wdata));
`else
        wr_ok_s  = 1'b1;
`endif
        mem_we_s   = load_s && prog_we && wr_ok_s;
        prog_err_d = prog_we && !mem_we_s;
        if (run_s && prog_start && !prog_done) begin
            prog_cnt_d = '0;
        end else if (mem_we_s && (prog_cnt_q != (ADDR_W+1)'(DEPTH))) begin
            prog_cnt_d = prog_cnt_q + (ADDR_W+1)'(1);
        end else begin
            prog_cnt_d = prog_cnt_q;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_err_q   <= 2'b00;
            prog_cnt_q    <= '0;
            prog_err_q    <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
            prog_cnt_q    <= prog_cnt_d;
            prog_err_q    <= prog_err_d;
        end
    end

    // Storage array is deliberately outside reset so images survive it
    always @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[prog_addr] <= prog_wdata;
`ifdef IMEM_PARITY_EN
            par_q[prog_addr] <= wr_par_s;
`endif
        end
    end

    // Port drivers
    always_comb begin
        fetch_valid = fetch_valid_q;
        fetch_data  = fetch_data_q;
        fetch_err   = fetch_err_q;
        prog_cnt    = prog_cnt_q;
        prog_err    = prog_err_q;
    end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable (ADDR_W=8, FETCH_BYTES=4, BOOT_LOAD=1).
module tb_inst_mem_loadable;

    localparam int ADDR_W = 8;
    localparam int FB     = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [8*FB-1:0]   fetch_data;
    logic [1:0]        fetch_err;
    logic              prog_start = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [7:0]        prog_wdata = '0;
    logic              prog_done = 1'b0;
    logic [ADDR_W:0]   prog_cnt;
    logic              prog_err;

    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    int checks = 0;
    int errors = 0;

    inst_mem_loadable #(.ADDR_W(ADDR_W), .FETCH_BYTES(FB), .BOOT_LOAD(1'b1), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .prog_start(prog_start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_done(prog_done), .prog_cnt(prog_cnt), .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pwrite(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
        fetch_req = 1'b1; fetch_addr = a;
        exp_q.push_back({e, d});
        cyc();
        fetch_req = 1'b0;
    endtask

    // Monitor: every presented fetch result is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && fetch_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %h expected no response", fetch_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("fetch_data", fetch_data, mon_e[31:0]);
                check("fetch_err", {30'b0, fetch_err}, {30'b0, mon_e[33:32]});
            end
        end
    end

    initial begin
        repeat (2) cyc();
        check("rst_ready", {31'b0, fetch_ready}, 32'd0);
        check("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_data", fetch_data, 32'd0);
        check("rst_err", {30'b0, fetch_err}, 32'd0);
        check("rst_cnt", {23'b0, prog_cnt}, 32'd0);
        check("rst_perr", {31'b0, prog_err}, 32'd0);
        rst = 1'b0;
        cyc();

        // Boot load, last byte written together with prog_done
        pwrite(8'd0, 8'h33);
        pwrite(8'd1, 8'h00);
        pwrite(8'd2, 8'h00);
        prog_done = 1'b1;
        pwrite(8'd3, 8'h00);
        prog_done = 1'b0;
        check("done_we_ready", {31'b0, fetch_ready}, 32'd1);
        check("boot_cnt", {23'b0, prog_cnt}, 32'd4);
        fetch(8'd0, 32'h0000_0033, 2'b00);

        // start+done together while running: stay in RUN
        prog_start = 1'b1; prog_done = 1'b1;
        cyc();
        prog_start = 1'b0; prog_done = 1'b0;
        check("start_done_run", {31'b0, fetch_ready}, 32'd1);

        prog_start = 1'b1;
        cyc();
        prog_start = 1'b0;
        check("enter_load_ready", {31'b0, fetch_ready}, 32'd0);
        check("enter_load_cnt", {23'b0, prog_cnt}, 32'd0);

        prog_start = 1'b1;
        pwrite(8'd4, 8'h11);
        prog_start = 1'b0;
        check("start_in_load", {31'b0, fetch_ready}, 32'd0);
        pwrite(8'd5, 8'h22); pwrite(8'd6, 8'h33); pwrite(8'd7, 8'h44);
        pwrite(8'd8, 8'h55); pwrite(8'd9, 8'h66); pwrite(8'd10, 8'h77); pwrite(8'd11, 8'h88);
        pwrite(8'd12, 8'h99); pwrite(8'd13, 8'haa); pwrite(8'd14, 8'hbb); pwrite(8'd15, 8'hcc);
        pwrite(8'd252, 8'hde); pwrite(8'd253, 8'had); pwrite(8'd254, 8'hbe); pwrite(8'd255, 8'hef);
        check("load_cnt", {23'b0, prog_cnt}, 32'd16);
        prog_done = 1'b1;
        cyc();
        prog_done = 1'b0;
        check("back_to_run", {31'b0, fetch_ready}, 32'd1);

        // Back-to-back fetches and fault cases
        fetch(8'd4, 32'h4433_2211, 2'b00);
        fetch(8'd8, 32'h8877_6655, 2'b00);
        fetch(8'd12, 32'hccbb_aa99, 2'b00);
        fetch(8'd252, 32'hefbe_adde, 2'b00);
        fetch(8'd6, NOP, 2'b01);
        fetch(8'd254, NOP, 2'b11);
        fetch(8'd253, NOP, 2'b11);
        fetch(8'd2, NOP, 2'b01);

        // Write strobe while running is dropped
        pwrite(8'd4, 8'hff);
        check("perr_pulse", {31'b0, prog_err}, 32'd1);
        cyc();
        check("perr_clear", {31'b0, prog_err}, 32'd0);
        fetch(8'd4, 32'h4433_2211, 2'b00);

        // prog_start alongside an accepted fetch
        prog_start = 1'b1;
        fetch(8'd0, 32'h0000_0033, 2'b00);
        prog_start = 1'b0;
        check("start_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 8'd4;
        cyc();
        fetch_req = 1'b0;
        check("load_no_valid", {31'b0, fetch_valid}, 32'd0);
        check("load_data_hold", fetch_data, 32'h0000_0033);

        // Reset in the middle of a load
        pwrite(8'd0, 8'ha1);
        pwrite(8'd1, 8'hb2);
        check("partial_cnt", {23'b0, prog_cnt}, 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, fetch_valid}, 32'd0);
        check("midrst_cnt", {23'b0, prog_cnt}, 32'd0);
        cyc();
        rst = 1'b0;
        prog_done = 1'b1;
        cyc();
        prog_done = 1'b0;
        fetch(8'd0, 32'h0000_b2a1, 2'b00);

        // Counter saturation
        prog_start = 1'b1;
        cyc();
        prog_start = 1'b0;
        for (int i = 0; i < 257; i++) begin
            pwrite(i[7:0], i[7:0]);
        end
        check("cnt_saturate", {23'b0, prog_cnt}, 32'd256);
        prog_done = 1'b1;
        cyc();
        prog_done = 1'b0;
        fetch(8'd16, 32'h1312_1110, 2'b00);
        fetch(8'd252, 32'hfffe_fdfc, 2'b00);

`ifdef IMEM_PARITY_EN
        dut.par_q[8] = ~dut.par_q[8];
        fetch(8'd8, NOP, 2'b10);
        fetch(8'd12, 32'h0f0e_0d0c, 2'b00);
`endif

        repeat (3) cyc();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
